// File: rtl/minicpu_mc_core.sv
// rtl/minicpu_mc_core.sv - multi-cycle LoongArch-subset core (IF/DE/MEM/WB) with req/ack SRAM ports.
// Defining MINICPU_TRACE_EN adds the debug_wb_* writeback trace ports.

module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] rf [32];

    always_ff @(posedge clk) begin
        if (we) begin
            rf[waddr] <= wdata;
        end
    end

    // r0 is hardwired on read so it is zero even though the array is never cleared
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

module minicpu_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_sram_req,
    output logic [31:0]      inst_sram_addr,
    input  logic [31:0]      inst_sram_rdata,
    input  logic             inst_sram_ack,
    output logic             data_sram_req,
    output logic             data_sram_we,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic [31:0]      data_sram_rdata,
    input  logic             data_sram_ack,
    output logic [CNT_W-1:0] inst_retired
`ifdef MINICPU_TRACE_EN
    ,
    output logic [31:0]      debug_wb_pc,
    output logic             debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
`endif
);

    typedef enum logic [1:0] {
        S_IF  = 2'd0,
        S_DE  = 2'd1,
        S_MEM = 2'd2,
        S_WB  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic        run_q;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] nextpc_r;
    logic [31:0] res_r;
    logic [31:0] st_data_r;
    logic        is_mem_r;
    logic        is_st_r;
    logic        rf_we_r;
    logic [4:0]  dest_r;
    logic [CNT_W-1:0] retired;

    logic [4:0]  rd, rj, rk;
    logic [31:0] si12, offs16, offs26;
    logic        is_add, is_sub, is_addi, is_ld, is_st, is_beq, is_bne, is_b;
    logic        dec_we;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] alu_res;
    logic [31:0] nextpc;
    logic        rf_we;
    logic        inst_fire, data_fire;

    assign rd = ir[4:0];
    assign rj = ir[9:5];
    assign rk = ir[14:10];

    assign si12   = {{20{ir[21]}}, ir[21:10]};
    assign offs16 = {{14{ir[25]}}, ir[25:10], 2'b00};
    assign offs26 = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};

    assign is_add  = ir[31:15] == {6'h00, 4'h0, 2'h1, 5'h00};
    assign is_sub  = ir[31:15] == {6'h00, 4'h0, 2'h1, 5'h02};
    assign is_addi = ir[31:22] == {6'h00, 4'ha};
    assign is_ld   = ir[31:22] == {6'h0a, 4'h2};
    assign is_st   = ir[31:22] == {6'h0a, 4'h6};
    assign is_beq  = ir[31:26] == 6'h16;
    assign is_bne  = ir[31:26] == 6'h17;
    assign is_b    = ir[31:26] == 6'h14;

    assign dec_we    = is_add | is_sub | is_addi | is_ld;
    assign rf_raddr2 = (is_st | is_beq | is_bne) ? rd : rk;

    regfile u_regfile (
        .clk    (clk),
        .raddr1 (rj),
        .rdata1 (rf_rdata1),
        .raddr2 (rf_raddr2),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (dest_r),
        .wdata  (res_r)
    );

    always_comb begin
        alu_res = 32'd0;
        if (is_add) begin
            alu_res = rf_rdata1 + rf_rdata2;
        end else if (is_sub) begin
            alu_res = rf_rdata1 - rf_rdata2;
        end else if (is_addi | is_ld | is_st) begin
            alu_res = rf_rdata1 + si12;
        end
    end

    always_comb begin
        nextpc = pc + 32'd4;
        if (is_b) begin
            nextpc = pc + offs26;
        end else if ((is_beq && rf_rdata1 == rf_rdata2) || (is_bne && rf_rdata1 != rf_rdata2)) begin
            nextpc = pc + offs16;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IF;
        end else begin
            state <= state_nx;
        end
    end

    // run_q keeps the fetch request low for the first cycle after any reset edge
    always_comb begin
        state_nx      = state;
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        case (state)
            S_IF: begin
                inst_sram_req = run_q;
                if (run_q && inst_sram_ack) begin
                    state_nx = S_DE;
                end
            end
            S_DE: begin
                state_nx = (is_ld | is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                data_sram_req = 1'b1;
                if (data_sram_ack) begin
                    state_nx = S_WB;
                end
            end
            S_WB: begin
                state_nx = S_IF;
            end
            default: begin
                state_nx = S_IF;
            end
        endcase
    end

    assign inst_fire = inst_sram_req & inst_sram_ack;
    assign data_fire = data_sram_req & data_sram_ack;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q   <= 1'b0;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            run_q <= 1'b1;
            case (state)
                S_IF: begin
                    if (inst_fire) begin
                        ir <= inst_sram_rdata;
                    end
                end
                S_DE: begin
                    nextpc_r  <= nextpc;
                    res_r     <= alu_res;
                    st_data_r <= rf_rdata2;
                    is_mem_r  <= is_ld | is_st;
                    is_st_r   <= is_st;
                    rf_we_r   <= dec_we && (rd != 5'd0);
                    dest_r    <= rd;
                end
                S_MEM: begin
                    // load data replaces the address so writeback always uses res_r
                    if (data_fire && !is_st_r) begin
                        res_r <= data_sram_rdata;
                    end
                end
                S_WB: begin
                    pc      <= nextpc_r;
                    retired <= retired + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_we = (state == S_WB) && rf_we_r && resetn;

    assign inst_sram_addr  = pc;
    assign data_sram_we    = is_st_r & is_mem_r;
    assign data_sram_addr  = res_r;
    assign data_sram_wdata = st_data_r;
    assign inst_retired    = retired;

`ifdef MINICPU_TRACE_EN
    assign debug_wb_pc       = (state == S_WB) ? pc : 32'd0;
    assign debug_wb_rf_we    = rf_we;
    assign debug_wb_rf_wnum  = (state == S_WB) ? dest_r : 5'd0;
    assign debug_wb_rf_wdata = (state == S_WB) ? res_r : 32'd0;
`endif

endmodule

// File: tb/tb_minicpu_mc_core.sv
// tb/tb_minicpu_mc_core.sv - randomized bench for minicpu_mc_core against an ISA-level model.

module tb_minicpu_mc_core;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          CNT_W    = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic        inst_sram_ack = 1'b0;
    logic        data_sram_req;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'd0;
    logic        data_sram_ack = 1'b0;
    logic [CNT_W-1:0] inst_retired;
`ifdef MINICPU_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic        debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    minicpu_mc_core #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_req   (inst_sram_req),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_sram_ack   (inst_sram_ack),
        .data_sram_req   (data_sram_req),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_sram_ack   (data_sram_ack),
        .inst_retired    (inst_retired)
`ifdef MINICPU_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] prog [64];
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] mreg [32];
    logic [31:0] mpc = RESET_PC;
    int          mcount = 0;

    bit          mem_pending = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0;
    bit          exp_we = 0;
    bit          exp_tr_we = 0, tr_seen = 1;
    logic [4:0]  exp_tr_wnum = 0;
    logic [31:0] exp_tr_wdata = 0, exp_tr_pc = 0;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5a5a0f0f;
    endfunction

    function automatic logic [31:0] dmem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] mmem_rd(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : mem_default(a);
    endfunction

    // Instruction-level interpreter: one call retires one instruction.
    task automatic model_exec(input logic [31:0] w);
        logic [4:0]  rd, rj, rk;
        logic [31:0] vj, vk, vd, si, npc, res;
        bit          wr;
        rd = w[4:0]; rj = w[9:5]; rk = w[14:10];
        vj = mreg[rj]; vk = mreg[rk]; vd = mreg[rd];
        si = {{20{w[21]}}, w[21:10]};
        npc = mpc + 32'd4; wr = 0; res = 32'd0;
        if (w[31:15] == {6'h00, 4'h0, 2'h1, 5'h00}) begin
            wr = 1; res = vj + vk;
        end else if (w[31:15] == {6'h00, 4'h0, 2'h1, 5'h02}) begin
            wr = 1; res = vj - vk;
        end else if (w[31:22] == {6'h00, 4'ha}) begin
            wr = 1; res = vj + si;
        end else if (w[31:22] == {6'h0a, 4'h2}) begin
            exp_addr = vj + si; exp_we = 0; mem_pending = 1;
            wr = 1; res = mmem_rd(exp_addr);
        end else if (w[31:22] == {6'h0a, 4'h6}) begin
            exp_addr = vj + si; exp_we = 1; exp_wdata = vd; mem_pending = 1;
            mmem[exp_addr] = vd;
        end else if (w[31:26] == 6'h16) begin
            if (vj == vd) npc = mpc + {{14{w[25]}}, w[25:10], 2'b00};
        end else if (w[31:26] == 6'h17) begin
            if (vj != vd) npc = mpc + {{14{w[25]}}, w[25:10], 2'b00};
        end else if (w[31:26] == 6'h14) begin
            npc = mpc + {{4{w[9]}}, w[9:0], w[25:10], 2'b00};
        end
        exp_tr_we = wr && (rd != 5'd0);
        exp_tr_wnum = rd; exp_tr_wdata = res; exp_tr_pc = mpc; tr_seen = 0;
        if (wr && rd != 5'd0) mreg[rd] = res;
        mpc = npc;
        mcount++;
    endtask

    function automatic logic [31:0] rand_inst();
        int          kind;
        logic [4:0]  rd, rj, rk;
        logic [11:0] si;
        logic [15:0] o16;
        logic [25:0] o26;
        kind = $urandom_range(0, 8);
        rd = 5'($urandom_range(0, 7));
        rj = 5'($urandom_range(0, 7));
        rk = 5'($urandom_range(0, 7));
        si = 12'($urandom);
        o16 = 16'($urandom_range(1, 3));
        o26 = 26'($urandom_range(1, 3));
        case (kind)
            0: return {6'h00, 4'h0, 2'h1, 5'h00, rk, rj, rd};
            1: return {6'h00, 4'h0, 2'h1, 5'h02, rk, rj, rd};
            2: return {6'h00, 4'ha, si, rj, rd};
            3: return {6'h0a, 4'h2, 12'h040 + 12'($urandom_range(0, 15) << 2), 5'd0, rd};
            4: return {6'h0a, 4'h6, 12'h040 + 12'($urandom_range(0, 15) << 2), 5'd0, rd};
            5: return {6'h16, o16, rj, rd};
            6: return {6'h17, o16, rj, rd};
            7: return {6'h14, o26[15:0], o26[25:16]};
            default: begin
                case ($urandom_range(0, 2))
                    0: return 32'hffffffff;
                    1: return 32'h00000000;
                    default: return {6'h3f, 26'($urandom)};
                endcase
            end
        endcase
    endfunction

    int max_delay = 0;
    int i_wait = -1, d_wait = -1, idle_cycles = 0;
    bit freeze_all = 0, freeze_data = 0;

    // Memory responder with random ack latency plus stray acks on idle ports.
    always @(negedge clk) begin
        logic [31:0] off;
        inst_sram_ack = 1'b0;
        data_sram_ack = 1'b0;
        inst_sram_rdata = $urandom;
        data_sram_rdata = $urandom;
        if (!resetn || freeze_all) begin
            i_wait = -1; d_wait = -1; idle_cycles = 0;
        end else begin
            idle_cycles++;
            if (idle_cycles == 60) check("fetch_timeout", 32'd0, 32'd1);
            if (inst_sram_req) begin
                if (i_wait < 0) i_wait = $urandom_range(0, max_delay);
                if (i_wait == 0) begin
                    off = inst_sram_addr - RESET_PC;
                    inst_sram_ack = 1'b1;
                    inst_sram_rdata = prog[off[7:2]];
                    check("fetch_pc", inst_sram_addr, mpc);
                    check("retired_at_fetch", inst_retired, mcount);
                    check("mem_done_before_fetch", {31'd0, mem_pending}, 32'd0);
`ifdef MINICPU_TRACE_EN
                    check("trace_wb_seen", {31'd0, exp_tr_we && !tr_seen}, 32'd0);
`endif
                    model_exec(prog[off[7:2]]);
                    idle_cycles = 0;
                    i_wait = -1;
                end else begin
                    i_wait--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                inst_sram_ack = 1'b1;
            end
            if (data_sram_req) begin
                check("data_req_expected", {31'd0, mem_pending}, 32'd1);
                check("data_addr", data_sram_addr, exp_addr);
                check("data_we", {31'd0, data_sram_we}, {31'd0, exp_we});
                if (exp_we) check("data_wdata", data_sram_wdata, exp_wdata);
                if (!freeze_data) begin
                    if (d_wait < 0) d_wait = $urandom_range(0, max_delay);
                    if (d_wait == 0) begin
                        data_sram_ack = 1'b1;
                        if (data_sram_we) dmem[data_sram_addr] = data_sram_wdata;
                        else data_sram_rdata = dmem_rd(data_sram_addr);
                        mem_pending = 0;
                        d_wait = -1;
                    end else begin
                        d_wait--;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                data_sram_ack = 1'b1;
            end
        end
    end

`ifdef MINICPU_TRACE_EN
    always @(negedge clk) begin
        if (resetn && !freeze_all && debug_wb_rf_we) begin
            check("trace_we_expected", {31'd0, exp_tr_we && !tr_seen}, 32'd1);
            check("trace_pc", debug_wb_pc, exp_tr_pc);
            check("trace_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, exp_tr_wnum});
            check("trace_wdata", debug_wb_rf_wdata, exp_tr_wdata);
            tr_seen = 1;
        end
    end
`endif

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        prog[0]  = {6'h00, 4'ha, 12'd5, 5'd0, 5'd1};               // addi.w r1,r0,5
        prog[1]  = {6'h00, 4'h0, 2'h1, 5'h00, 5'd1, 5'd1, 5'd2};   // add.w r2,r1,r1
        prog[2]  = {6'h00, 4'h0, 2'h1, 5'h02, 5'd1, 5'd2, 5'd3};   // sub.w r3,r2,r1
        prog[3]  = {6'h0a, 4'h6, 12'h010, 5'd0, 5'd2};             // st.w r2,r0,0x10
        prog[4]  = {6'h0a, 4'h2, 12'h020, 5'd0, 5'd4};             // ld.w r4,r0,0x20
        prog[5]  = {6'h00, 4'ha, 12'd1, 5'd0, 5'd0};               // addi.w r0,r0,1
        prog[6]  = {6'h0a, 4'h6, 12'h014, 5'd0, 5'd4};
        prog[7]  = {6'h0a, 4'h6, 12'h018, 5'd0, 5'd0};
        prog[8]  = {6'h0a, 4'h6, 12'h01c, 5'd0, 5'd3};
        prog[9]  = {6'h17, 16'd2, 5'd1, 5'd1};                     // bne equal: falls through
        prog[10] = {6'h14, 16'd3, 10'd0};                          // b -> 13
        prog[11] = {6'h14, 16'd3, 10'd0};                          // b -> 14
        prog[12] = {6'h00, 4'ha, 12'h7ff, 5'd0, 5'd1};
        prog[13] = {6'h16, 16'hfffe, 5'd1, 5'd1};                  // beq -2 -> 11
        prog[14] = 32'hffffffff;
        prog[15] = {6'h00, 4'ha, 12'hffd, 5'd0, 5'd5};
        prog[16] = {6'h00, 4'ha, 12'h123, 5'd0, 5'd6};
        prog[17] = {6'h00, 4'ha, 12'd1, 5'd6, 5'd7};
        prog[18] = {6'h14, 16'h0101, 10'd0};                       // b +0x404
        prog[19] = {6'h0a, 4'h6, 12'h024, 5'd0, 5'd1};
        for (int i = 20; i < 64; i++) prog[i] = rand_inst();
        dmem[32'h20] = 32'hdeadbeef;
        mmem[32'h20] = 32'hdeadbeef;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_inst_req", {31'd0, inst_sram_req}, 32'd0);
        check("reset_data_req", {31'd0, data_sram_req}, 32'd0);
        check("reset_retired", inst_retired, 32'd0);
`ifdef MINICPU_TRACE_EN
        check("reset_trace_we", {31'd0, debug_wb_rf_we}, 32'd0);
`endif
        resetn = 1'b1;
        @(posedge clk); #1;
        check("first_req", {31'd0, inst_sram_req}, 32'd1);
        check("first_addr", inst_sram_addr, RESET_PC);
        check("first_retired", inst_retired, 32'd0);
        // Zero-wait: one retirement every three cycles after the first request.
        for (int e = 2; e <= 10; e++) begin
            @(posedge clk); #1;
            check("zero_wait_retired", inst_retired, 32'((e - 1) / 3));
        end

        max_delay = 4;
        repeat (3000) @(posedge clk);
        check("progress", {31'd0, mcount > 100}, 32'd1);
        check("st_r2_0x10", dmem_rd(32'h10), 32'd10);
        check("ld_deadbeef_0x14", dmem_rd(32'h14), 32'hdeadbeef);
        check("r0_reads_zero_0x18", dmem_rd(32'h18), 32'd0);
        check("st_r3_0x1c", dmem_rd(32'h1c), 32'd5);
        check("branch_path_0x24", dmem_rd(32'h24), 32'd5);

        freeze_data = 1;
        for (int k = 0; k < 400 && !data_sram_req; k++) @(negedge clk);
        check("mem_req_seen", {31'd0, data_sram_req}, 32'd1);
        freeze_all = 1;
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_data_req", {31'd0, data_sram_req}, 32'd0);
        check("midreset_inst_req", {31'd0, inst_sram_req}, 32'd0);
        check("midreset_pc", inst_sram_addr, RESET_PC);
        check("midreset_retired", inst_retired, 32'd0);
`ifdef MINICPU_TRACE_EN
        check("midreset_trace_we", {31'd0, debug_wb_rf_we}, 32'd0);
`endif
        resetn = 1'b1;
        @(posedge clk); #1;
        check("restart_req", {31'd0, inst_sram_req}, 32'd1);
        check("restart_addr", inst_sram_addr, RESET_PC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
